mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, memory access latency in cycles; legal range 1..15.
REQ-002 Parameter AW, default 32, address width.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 cpu_req  in  1  CPU (multicycle controller/datapath) access request; held high until cpu_ready.
REQ-006 cpu_we  in  1  1 = write, 0 = read.
REQ-007 cpu_addr  in  AW  CPU byte address.
REQ-008 cpu_wdata  in  32  CPU write data.
REQ-009 cpu_rdata  out  32  read data returned to CPU.
REQ-010 cpu_ready  out  1  one-cycle completion pulse to CPU.
REQ-011 cpu_stall  out  1  cpu_req AND NOT cpu_ready; freezes the CPU state machine.
REQ-012 dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ready  in/in/in/in/out/out  1/1/AW/32/32/1  second requester (loader/DMA), same meaning as the CPU port.
REQ-013 mem_en  out  1  memory access strobe.
REQ-014 mem_we  out  1  memory write enable; valid only while mem_en is high.
REQ-015 mem_addr  out  AW  memory address.
REQ-016 mem_wdata  out  32  memory write data.
REQ-017 mem_rdata  in  32  memory read data; valid in the last mem_en cycle of an access.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, BUSY and RESP.
REQ-019 IDLE with no request: stay IDLE; mem_en = 0; both ready outputs = 0.
REQ-020 IDLE with exactly one request: grant it, latch its we/addr/wdata, set wait counter to WAIT_CYCLES-1, go BUSY.
REQ-021 IDLE with both requests: grant the requester not granted last (round-robin via last_grant register).
REQ-022 last_grant SHALL update on every grant.
REQ-023 BUSY: mem_en = 1, and mem_we/mem_addr/mem_wdata SHALL equal the latched values, stable for all WAIT_CYCLES cycles.
REQ-024 BUSY with counter ≠ 0: decrement the counter, stay BUSY.
REQ-025 BUSY with counter = 0: on a read, capture mem_rdata into the granted requester's rdata register; go RESP.
REQ-026 RESP: assert the granted requester's ready for exactly one cycle; mem_en = 0; go IDLE.
REQ-027 Latency: request first seen high in IDLE at cycle t → mem_en high t+1..t+WAIT_CYCLES → ready at t+WAIT_CYCLES+1.
REQ-028 Back-to-back throughput: one access per WAIT_CYCLES+2 cycles.
REQ-029 A request that is still high in the cycle after its ready pulse SHALL be treated as a new request.
REQ-030 A granted access SHALL always run to completion; deassertion of req or changes to addr/wdata mid-access SHALL be ignored.
REQ-031 A non-granted requester's ready SHALL stay 0, and its rdata SHALL hold its previous value.
REQ-032 A write SHALL leave the requester's rdata unchanged.
REQ-033 cpu_stall SHALL be combinational and is high whenever the CPU is waiting, including while the DMA owns the port.
REQ-034 mem_we, mem_addr and mem_wdata are don't-care while mem_en = 0, but SHALL NOT be X after reset.

Reset
REQ-035 On reset, the following SHALL take these values at the next edge: state = IDLE, counter = 0, last_grant = DMA (so the CPU wins the first tie), cpu_rdata = dma_rdata = 0, all outputs 0.
REQ-036 Reset during BUSY or RESP SHALL abort the access: mem_en = 0 from the next cycle, and no ready pulse is issued for the aborted access.

Verification
REQ-037 WAIT_CYCLES=2; CPU read addr 0x40, mem returns 0xDEADBEEF → mem_en high 2 cycles with addr 0x40, mem_we = 0; cpu_ready pulse at t+3; cpu_rdata = 0xDEADBEEF; cpu_stall high t..t+2.
REQ-038 Both requests rise at the same cycle after reset → CPU served first, DMA granted in the IDLE cycle after the CPU's ready; continuous contention alternates CPU, DMA, CPU, ...
REQ-039 DMA write addr 0x100 data 0x12345678, cpu_req low → mem_we = 1 for 2 cycles with stable addr/data; dma_ready pulse once; dma_rdata unchanged.
REQ-040 CPU drops cpu_req and changes cpu_addr during BUSY → access completes on the original address with one ready pulse.
REQ-041 Reset asserted in the second BUSY cycle → mem_en = 0 next cycle, no ready pulse, state IDLE, next tie goes to CPU.
REQ-042 WAIT_CYCLES=1 sweep → ready at t+2; back-to-back CPU reads spaced 3 cycles apart.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-requester (CPU and DMA) arbiter in front of a single fixed-latency
// memory port. Each access takes WAIT_CYCLES memory cycles with stable
// address/data, followed by a one-cycle ready pulse to the requester that
// owned it. Ties are broken round-robin, with the CPU winning the first
// tie after reset.
//
// Parameters
//   WAIT_CYCLES : memory access latency in cycles (1..15)
//   AW          : address width
// Ports
//   clk, reset                        : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata             : CPU request, held until cpu_ready
//   cpu_rdata, cpu_ready, cpu_stall   : CPU read data, completion pulse, stall
//   dma_req/we/addr/wdata             : DMA request, held until dma_ready
//   dma_rdata, dma_ready              : DMA read data, completion pulse
//   mem_en/we/addr/wdata              : memory strobe, write enable, address, data
//   mem_rdata                         : memory read data (valid in last mem_en cycle)
module mem_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int AW          = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_ready,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [31:0]   dma_wdata,
  output logic [31:0]   dma_rdata,
  output logic          dma_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Grant encoding shared by grant_q and last_grant_q.
  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_DMA = 1'b1;

  // Counter is loaded with WAIT_CYCLES-1 so BUSY lasts exactly WAIT_CYCLES cycles.
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t          state_q,      state_d;
  logic [3:0]      cnt_q,        cnt_d;
  logic            grant_q,      grant_d;
  logic            last_grant_q, last_grant_d;
  logic            mem_en_q,     mem_en_d;
  logic            mem_we_q,     mem_we_d;
  logic [AW-1:0]   mem_addr_q,   mem_addr_d;
  logic [31:0]     mem_wdata_q,  mem_wdata_d;
  logic [31:0]     cpu_rdata_q,  cpu_rdata_d;
  logic [31:0]     dma_rdata_q,  dma_rdata_d;
  logic            cpu_ready_q,  cpu_ready_d;
  logic            dma_ready_q,  dma_ready_d;
  logic            pick_dma;

  // Arbitration choice: on a tie, grant whoever was not granted last.
  always_comb begin
    pick_dma = 1'b0;
    if (cpu_req && dma_req) begin
      pick_dma = ~last_grant_q;
    end else begin
      pick_dma = dma_req;
    end
  end

  // Next-state and next-output computation for the IDLE/BUSY/RESP sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    cpu_ready_d  = 1'b0;
    dma_ready_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_req || dma_req) begin
          grant_d      = pick_dma;
          last_grant_d = pick_dma;
          mem_en_d     = 1'b1;
          mem_we_d     = pick_dma ? dma_we    : cpu_we;
          mem_addr_d   = pick_dma ? dma_addr  : cpu_addr;
          mem_wdata_d  = pick_dma ? dma_wdata : cpu_wdata;
          cnt_d        = CNT_INIT;
          state_d      = BUSY;
        end else begin
          state_d = IDLE;
        end
      end

      BUSY: begin
        if (cnt_q != 4'd0) begin
          // Latched request stays on the bus; live requester inputs are ignored.
          cnt_d    = cnt_q - 4'd1;
          mem_en_d = 1'b1;
          mem_we_d = mem_we_q;
          state_d  = BUSY;
        end else begin
          // Last memory cycle: mem_rdata is valid now. mem_we_q still holds
          // the latched direction here.
          if (!mem_we_q) begin
            if (grant_q == GRANT_DMA) begin
              dma_rdata_d = mem_rdata;
            end else begin
              cpu_rdata_d = mem_rdata;
            end
          end else begin
            cpu_rdata_d = cpu_rdata_q;
            dma_rdata_d = dma_rdata_q;
          end
          cpu_ready_d = (grant_q == GRANT_CPU);
          dma_ready_d = (grant_q == GRANT_DMA);
          state_d     = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      grant_q      <= GRANT_CPU;
      last_grant_q <= GRANT_DMA;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'd0;
      cpu_rdata_q  <= 32'd0;
      dma_rdata_q  <= 32'd0;
      cpu_ready_q  <= 1'b0;
      dma_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      cpu_ready_q  <= cpu_ready_d;
      dma_ready_q  <= dma_ready_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign dma_ready = dma_ready_q;

  // The CPU is frozen for every cycle it requests without completing,
  // including while the DMA owns the memory.
  assign cpu_stall = cpu_req & ~cpu_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus a randomized run
// against a timeline-based reference model (grant cycle g -> memory busy
// g+1..g+W, ready at g+W+1, arbiter free again at g+W+2).
module tb_mem_arbiter;

  localparam int W = 2;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ready, cpu_stall, dma_ready, mem_en, mem_we;
  logic [31:0] cpu_rdata1, dma_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        cpu_ready1, cpu_stall1, dma_ready1, mem_en1, mem_we1;
  logic        ovr;
  logic [31:0] ovr_val;

  int checks   = 0;
  int failures = 0;

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  assign mem_rdata  = ovr ? ovr_val : hash(mem_addr);
  assign mem_rdata1 = hash(mem_addr1);

  mem_arbiter #(.WAIT_CYCLES(W), .AW(32)) u0 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ready(dma_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.WAIT_CYCLES(1), .AW(32)) u1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata1), .cpu_ready(cpu_ready1), .cpu_stall(cpu_stall1),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata1), .dma_ready(dma_ready1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset   = 1'b1;
    cpu_req = 1'b0;
    dma_req = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; cpu_req = 1'b0; dma_req = 1'b0;
    tick(); tick();
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL rst_mem_en act=%h exp=0", mem_en); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we act=%h exp=0", mem_we); end
    checks++; if (mem_addr !== 32'd0) begin failures++; $display("FAIL rst_mem_addr act=%h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 32'd0) begin failures++; $display("FAIL rst_mem_wdata act=%h exp=0", mem_wdata); end
    checks++; if (cpu_ready !== 1'b0 || dma_ready !== 1'b0) begin failures++; $display("FAIL rst_ready act=%b%b exp=00", cpu_ready, dma_ready); end
    checks++; if (cpu_rdata !== 32'd0 || dma_rdata !== 32'd0) begin failures++; $display("FAIL rst_rdata act=%h/%h exp=0", cpu_rdata, dma_rdata); end
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL rst_stall act=%h exp=0", cpu_stall); end
    reset = 1'b0;
    tick();
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL idle_mem_en act=%h exp=0", mem_en); end
  endtask

  task automatic test_cpu_read;
    do_reset();
    ovr = 1'b1; ovr_val = 32'hDEADBEEF;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; cpu_wdata = 32'h0;
    #1;
    checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL rd_stall_t act=%h exp=1", cpu_stall); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (mem_en !== (k <= 2)) begin failures++; $display("FAIL rd_mem_en k=%0d act=%h exp=%h", k, mem_en, (k <= 2)); end
      checks++; if (cpu_ready !== (k == 3)) begin failures++; $display("FAIL rd_ready k=%0d act=%h exp=%h", k, cpu_ready, (k == 3)); end
      checks++; if (cpu_stall !== (k <= 2)) begin failures++; $display("FAIL rd_stall k=%0d act=%h exp=%h", k, cpu_stall, (k <= 2)); end
      if (k <= 2) begin
        checks++; if (mem_addr !== 32'h40 || mem_we !== 1'b0) begin failures++; $display("FAIL rd_bus k=%0d act=%h/%h exp=40/0", k, mem_addr, mem_we); end
      end
    end
    checks++; if (cpu_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data act=%h exp=deadbeef", cpu_rdata); end
    cpu_req = 1'b0; ovr = 1'b0;
    tick();
    checks++; if (cpu_ready !== 1'b0 || mem_en !== 1'b0) begin failures++; $display("FAIL rd_after act=%b%b exp=00", cpu_ready, mem_en); end
  endtask

  task automatic test_contention;
    logic [31:0] exp_a;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20;
    for (int n = 0; n < 4; n++) begin
      exp_a = (n % 2 == 0) ? 32'h10 : 32'h20;
      tick();
      checks++; if (mem_en !== 1'b1 || mem_addr !== exp_a) begin failures++; $display("FAIL rr_grant n=%0d act=%h/%h exp=1/%h", n, mem_en, mem_addr, exp_a); end
      checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL rr_stall n=%0d act=%h exp=1", n, cpu_stall); end
      tick(); tick();
      checks++; if (cpu_ready !== (n % 2 == 0) || dma_ready !== (n % 2 == 1)) begin failures++; $display("FAIL rr_ready n=%0d act=%b%b", n, cpu_ready, dma_ready); end
      if (n % 2 == 1) begin
        checks++; if (dma_rdata !== hash(32'h20)) begin failures++; $display("FAIL rr_dma_rdata act=%h exp=%h", dma_rdata, hash(32'h20)); end
      end else begin
        checks++; if (cpu_rdata !== hash(32'h10)) begin failures++; $display("FAIL rr_cpu_rdata act=%h exp=%h", cpu_rdata, hash(32'h10)); end
      end
      tick();
      checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL rr_idle n=%0d act=%h exp=0", n, mem_en); end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
  endtask

  task automatic test_dma_write;
    int pulses;
    do_reset();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h30;
    tick(); tick(); tick();
    dma_req = 1'b0;
    tick();
    checks++; if (dma_rdata !== hash(32'h30)) begin failures++; $display("FAIL wr_pre_rdata act=%h exp=%h", dma_rdata, hash(32'h30)); end
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h100; dma_wdata = 32'h12345678;
    pulses = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (dma_ready === 1'b1) pulses++;
      if (k <= 2) begin
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'h12345678) begin
          failures++; $display("FAIL wr_bus k=%0d act=%h/%h/%h/%h exp=1/1/100/12345678", k, mem_en, mem_we, mem_addr, mem_wdata);
        end
      end
      if (k == 3) begin
        checks++; if (dma_ready !== 1'b1 || cpu_ready !== 1'b0) begin failures++; $display("FAIL wr_ready act=%b%b exp=01", cpu_ready, dma_ready); end
        checks++; if (dma_rdata !== hash(32'h30)) begin failures++; $display("FAIL wr_rdata_kept act=%h exp=%h", dma_rdata, hash(32'h30)); end
        dma_req = 1'b0;
      end
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL wr_pulses act=%0d exp=1", pulses); end
  endtask

  task automatic test_mid_access;
    int pulses;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80; dma_req = 1'b0;
    pulses = 0;
    tick();
    cpu_req = 1'b0; cpu_addr = 32'h99; cpu_wdata = $urandom;
    checks++; if (mem_addr !== 32'h80) begin failures++; $display("FAIL mid_addr1 act=%h exp=80", mem_addr); end
    for (int k = 2; k <= 6; k++) begin
      tick();
      if (cpu_ready === 1'b1) pulses++;
      if (k == 2) begin
        checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h80) begin failures++; $display("FAIL mid_addr2 act=%h/%h exp=1/80", mem_en, mem_addr); end
      end
      if (k == 3) begin
        checks++; if (cpu_ready !== 1'b1 || cpu_rdata !== hash(32'h80)) begin failures++; $display("FAIL mid_done act=%h/%h exp=1/%h", cpu_ready, cpu_rdata, hash(32'h80)); end
      end
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL mid_pulses act=%0d exp=1", pulses); end
  endtask

  task automatic test_reset_abort;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h50; dma_req = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    checks++; if (mem_en !== 1'b0 || cpu_ready !== 1'b0) begin failures++; $display("FAIL abort_out act=%b%b exp=00", mem_en, cpu_ready); end
    checks++; if (cpu_rdata !== 32'd0) begin failures++; $display("FAIL abort_rdata act=%h exp=0", cpu_rdata); end
    reset = 1'b0;
    cpu_req = 1'b1; cpu_addr = 32'h60; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h70;
    tick();
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h60) begin failures++; $display("FAIL abort_tie act=%h/%h exp=1/60", mem_en, mem_addr); end
    tick(); tick();
    checks++; if (cpu_ready !== 1'b1 || cpu_rdata !== hash(32'h60)) begin failures++; $display("FAIL abort_next act=%h/%h exp=1/%h", cpu_ready, cpu_rdata, hash(32'h60)); end
    cpu_req = 1'b0; dma_req = 1'b0;
    tick();
  endtask

  task automatic test_wait1;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h44; dma_req = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++; if (mem_en1 !== (k % 3 == 1)) begin failures++; $display("FAIL w1_mem_en k=%0d act=%h exp=%h", k, mem_en1, (k % 3 == 1)); end
      checks++; if (cpu_ready1 !== (k % 3 == 2)) begin failures++; $display("FAIL w1_ready k=%0d act=%h exp=%h", k, cpu_ready1, (k % 3 == 2)); end
      if (k % 3 == 2) begin
        checks++; if (cpu_rdata1 !== hash(32'h44)) begin failures++; $display("FAIL w1_rdata act=%h exp=%h", cpu_rdata1, hash(32'h44)); end
      end
    end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_random;
    bit          act, own, last, out_c, out_d, e_en, e_cr, e_dr, we_l;
    int          g;
    logic [31:0] a_l, d_l, exp_crd, exp_drd;
    do_reset();
    act = 1'b0; last = 1'b1; out_c = 1'b0; out_d = 1'b0; g = 0;
    own = 1'b0; we_l = 1'b0; a_l = 32'd0; d_l = 32'd0;
    exp_crd = 32'd0; exp_drd = 32'd0;
    for (int c = 0; c < 400; c++) begin
      e_en = act && (c >= g + 1) && (c <= g + W);
      e_cr = act && !own && (c == g + W + 1);
      e_dr = act && own && (c == g + W + 1);
      if (e_cr && !we_l) exp_crd = hash(a_l);
      if (e_dr && !we_l) exp_drd = hash(a_l);
      checks++; if (mem_en !== e_en) begin failures++; $display("FAIL rnd_mem_en c=%0d act=%h exp=%h", c, mem_en, e_en); end
      checks++; if (cpu_ready !== e_cr || dma_ready !== e_dr) begin failures++; $display("FAIL rnd_ready c=%0d act=%b%b exp=%b%b", c, cpu_ready, dma_ready, e_cr, e_dr); end
      checks++; if (cpu_rdata !== exp_crd || dma_rdata !== exp_drd) begin failures++; $display("FAIL rnd_rdata c=%0d act=%h/%h exp=%h/%h", c, cpu_rdata, dma_rdata, exp_crd, exp_drd); end
      if (e_en) begin
        checks++; if (mem_we !== we_l || mem_addr !== a_l || (we_l && mem_wdata !== d_l)) begin
          failures++; $display("FAIL rnd_bus c=%0d act=%h/%h/%h exp=%h/%h/%h", c, mem_we, mem_addr, mem_wdata, we_l, a_l, d_l);
        end
      end
      if (e_cr) out_c = 1'b0;
      if (e_dr) out_d = 1'b0;
      // CPU stimulus
      if (!out_c) begin
        if ($urandom_range(0, 1) == 1) begin
          cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1)); cpu_addr = $urandom; cpu_wdata = $urandom; out_c = 1'b1;
        end else begin
          cpu_req = 1'b0;
        end
      end else if (e_en && !own) begin
        if ($urandom_range(0, 7) == 0) cpu_req = 1'b0;
        if ($urandom_range(0, 3) == 0) begin cpu_addr = $urandom; cpu_wdata = $urandom; end
      end
      // DMA stimulus
      if (!out_d) begin
        if ($urandom_range(0, 1) == 1) begin
          dma_req = 1'b1; dma_we = 1'($urandom_range(0, 1)); dma_addr = $urandom; dma_wdata = $urandom; out_d = 1'b1;
        end else begin
          dma_req = 1'b0;
        end
      end else if (e_en && own) begin
        if ($urandom_range(0, 7) == 0) dma_req = 1'b0;
        if ($urandom_range(0, 3) == 0) begin dma_addr = $urandom; dma_wdata = $urandom; end
      end
      #1;
      checks++; if (cpu_stall !== (cpu_req && !e_cr)) begin failures++; $display("FAIL rnd_stall c=%0d act=%h exp=%h", c, cpu_stall, (cpu_req && !e_cr)); end
      // Reference decision: arbiter free when idle, round-robin on ties.
      if (!act || c >= g + W + 2) begin
        act = 1'b0;
        if (cpu_req || dma_req) begin
          own  = (cpu_req && dma_req) ? !last : dma_req;
          we_l = own ? dma_we : cpu_we;
          a_l  = own ? dma_addr : cpu_addr;
          d_l  = own ? dma_wdata : cpu_wdata;
          g    = c;
          act  = 1'b1;
          last = own;
        end
      end
      tick();
    end
    cpu_req = 1'b0; dma_req = 1'b0;
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; ovr = 1'b0; ovr_val = 32'd0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'd0; dma_wdata = 32'd0;
    test_reset();
    test_cpu_read();
    test_contention();
    test_dma_write();
    test_mid_access();
    test_reset_abort();
    test_wait1();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
